// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU feeding the HI/LO register.
// One quotient bit per RUN cycle; result = {remainder, quotient}, ready is the HI/LO write strobe.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             sgn_q, sgn_r;
  logic             accept, last;
  logic [WIDTH:0]   trial, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // Magnitude taken in WIDTH+1 bits so the most negative operand stays exact.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH:0] ext;
    ext = $signed({sgn & x[WIDTH-1], x});
    if (ext < 0) ext = -ext;
    return ext[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  assign accept = (state == IDLE) && start && !annul;
  assign last   = (count == CW'(WIDTH - 1));

  // Trial subtraction: a clear top bit of diff means the divisor fits.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (b == '0) ? ZERO : RUN;
      ZERO: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) count <= '0;
      else if (state == RUN && !annul) count <= count + CW'(1);
      if (!annul) begin
        if (state == RUN && last)
          result <= {cond_neg(rem_nxt, sgn_r), cond_neg(quo_nxt, sgn_q)};
        else if (state == ZERO)
          result <= {quo, {WIDTH{1'b1}}};
      end
    end
  end

  // Working registers; for a zero divisor quo carries the raw dividend into ZERO.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs   <= mag(b, signed_div);
      quo   <= (b == '0) ? a : mag(a, signed_div);
      rem   <= '0;
      sgn_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
      sgn_r <= signed_div & a[WIDTH-1];
    end else if (state == RUN) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule
